// File: rtl/blue_motion_ctrl.sv
// ---------------------------------------------------------------------------
// blue_motion_ctrl
// Player-position controller for the blue character. A free-running divider
// produces a one-cycle motion tick. On each tick the controller walks the
// sprite horizontally and advances a GROUND/JUMP/FALL vertical state machine,
// using the collision flags computed from the previous position.
//
// Ports
//   clk           in   1   system clock
//   rst           in   1   asynchronous reset, active-high
//   key_left      in   1   move-left request (level)
//   key_right     in   1   move-right request (level)
//   key_up        in   1   jump request (level)
//   is_Collision  in   4   {left, right, up(head), down(feet)} collision flags
//   x_blue        out  10  sprite top-left x (registered)
//   y_blue        out  9   sprite top-left y (registered)
//   motion_state  out  2   00 GROUND, 01 JUMP, 10 FALL
//   tick          out  1   one-cycle pulse marking the motion-update cycle
// ---------------------------------------------------------------------------
module blue_motion_ctrl #(
    parameter int         TICK_DIV   = 500000,
    parameter int         STEP_X     = 2,
    parameter int         STEP_Y     = 2,
    parameter int         JUMP_TICKS = 20,
    parameter logic [9:0] X_INIT     = 10'd40,
    parameter logic [8:0] Y_INIT     = 9'd300,
    parameter logic [9:0] X_MAX      = 10'd593,
    parameter logic [8:0] Y_MAX      = 9'd439
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [1:0] motion_state,
    output logic       tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int JW = $clog2(JUMP_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);
    localparam logic [JW-1:0] JMP_LIM  = JW'(JUMP_TICKS);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_JUMP   = 2'b01,
        ST_FALL   = 2'b10
    } state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic [JW-1:0] jump_cnt;
    logic [JW-1:0] jump_cnt_inc;
    logic [9:0]    x_next;
    logic [8:0]    y_up;
    logic [8:0]    y_down;
    logic          go_right;
    logic          go_left;

    // Saturating arithmetic: every sum/difference is formed one bit wider so
    // the carry/borrow is visible, then clamped instead of wrapping.
    function automatic logic [9:0] x_add_sat(input logic [9:0] x);
        logic [10:0] s;
        s = {1'b0, x} + 11'(STEP_X);
        if (s > {1'b0, X_MAX}) return X_MAX;
        else                   return s[9:0];
    endfunction

    function automatic logic [9:0] x_sub_sat(input logic [9:0] x);
        logic [10:0] d;
        d = {1'b0, x} - 11'(STEP_X);
        if (d[10]) return 10'd0;
        else       return d[9:0];
    endfunction

    function automatic logic [8:0] y_add_sat(input logic [8:0] y);
        logic [9:0] s;
        s = {1'b0, y} + 10'(STEP_Y);
        if (s > {1'b0, Y_MAX}) return Y_MAX;
        else                   return s[8:0];
    endfunction

    function automatic logic [8:0] y_sub_sat(input logic [8:0] y);
        logic [9:0] d;
        d = {1'b0, y} - 10'(STEP_Y);
        if (d[9]) return 9'd0;
        else      return d[8:0];
    endfunction

    assign motion_state = state;

    // Candidate next positions; only committed by the FSM on a tick.
    always_comb begin
        go_right     = key_right & ~key_left & ~is_Collision[2];
        go_left      = key_left & ~key_right & ~is_Collision[3];
        y_up         = y_sub_sat(y_blue);
        y_down       = y_add_sat(y_blue);
        jump_cnt_inc = jump_cnt + JW'(1);
        if (go_right) begin
            x_next = x_add_sat(x_blue);
        end else if (go_left) begin
            x_next = x_sub_sat(x_blue);
        end else begin
            x_next = x_blue;
        end
    end

    // Motion tick divider; tick is registered one count early so that it is
    // high exactly while the counter sits at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            if (div_cnt == CNT_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + CW'(1);
            tick <= (div_cnt == CNT_PRE);
        end
    end

    // Position and vertical FSM, updated only on the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_blue   <= X_INIT;
            y_blue   <= Y_INIT;
            state    <= ST_FALL;
            jump_cnt <= '0;
        end else if (tick) begin
            x_blue <= x_next;
            case (state)
                ST_GROUND: begin
                    // Feet checked first: no jump once the floor has gone.
                    if (!is_Collision[0]) begin
                        state <= ST_FALL;
                    end else if (key_up) begin
                        state    <= ST_JUMP;
                        jump_cnt <= '0;
                    end
                end
                ST_JUMP: begin
                    // Head hit wins over the rise limit; y holds that tick.
                    if (is_Collision[1]) begin
                        state <= ST_FALL;
                    end else begin
                        y_blue   <= y_up;
                        jump_cnt <= jump_cnt_inc;
                        if ((jump_cnt_inc >= JMP_LIM) || (y_up == 9'd0)) begin
                            state <= ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (is_Collision[0]) begin
                        state <= ST_GROUND;
                    end else begin
                        y_blue <= y_down;
                        // Bottom of the screen acts as a floor.
                        if (y_down == Y_MAX) state <= ST_GROUND;
                    end
                end
                default: begin
                    state <= ST_FALL;
                end
            endcase
        end
    end

endmodule
